// File: rtl/hist_xfer_pkg.sv
// Shared types and constants for the histogram BRAM <-> SD transfer engine.
// Holds the FSM state enum, sector size, mode encodings and a log2 helper.
package hist_xfer_pkg;

  localparam int SECTOR_BYTES = 512;

  localparam logic MODE_SAVE = 1'b0;
  localparam logic MODE_LOAD = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_XFER      = 3'd3,
    S_NEXT      = 3'd4,
    S_FINISH    = 3'd5
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/byte_lane_mux.sv
// Byte lane select/insert for one BRAM word, ordered by MSB_FIRST.
// Ports: word_i/idx_i/byte_i in; byte_o (selected lane), word_o (lane replaced).
module byte_lane_mux
  import hist_xfer_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter bit MSB_FIRST = 1'b1,
  parameter int LANE_W    = 1
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [LANE_W-1:0] idx_i,
  input  logic [7:0]        byte_i,
  output logic [7:0]        byte_o,
  output logic [DATA_W-1:0] word_o
);

  localparam int BPW = DATA_W / 8;

  logic [LANE_W-1:0] lane;
  int                sh;

  always_comb begin
    // Transfer index 0 maps to the top lane when MSB goes first.
    lane   = MSB_FIRST ? (LANE_W'(BPW - 1) - idx_i) : idx_i;
    sh     = 8 * int'(lane);
    byte_o = word_i[sh +: 8];
    word_o = word_i;
    word_o[sh +: 8] = byte_i;
  end

endmodule

// File: rtl/histogram_xfer.sv
// Save/load a slot of SECTORS 512-byte sectors between histogram BRAM and SD.
// Ports: start/mode/slot cmd, mem_* BRAM port, sd_* controller, busy/done/err,
// cksum/cksum_exp. Optional running checksum under HIST_XFER_CKSUM_EN.
module histogram_xfer
  import hist_xfer_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int SECTORS    = 4,
  parameter int SLOT_W     = 7,
  parameter int SLOT_SHIFT = 11,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int TIMEOUT    = 1 << 20,
  parameter int ADDR_W     = clog2(SECTORS * 4096 / DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [SLOT_W-1:0] slot,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic              sd_ready,
  output logic [31:0]       sd_address,
  output logic              sd_wr,
  output logic              sd_rd,
  output logic [7:0]        sd_din,
  input  logic              sd_ready_for_next_byte,
  input  logic [7:0]        sd_dout,
  input  logic              sd_byte_available,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       cksum,
  input  logic [15:0]       cksum_exp
);

  localparam int BPW    = DATA_W / 8;
  localparam int LANE_W = (BPW > 1) ? clog2(BPW) : 1;
  localparam int WPS    = SECTOR_BYTES * 8 / DATA_W;
  localparam int SEC_W  = (SECTORS > 1) ? clog2(SECTORS) : 1;

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [31:0]       addr_q, addr_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [9:0]        bidx_q, bidx_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [7:0]        din_q, din_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       tmo_q, tmo_d;
  logic [15:0]       cks_q, cks_d;
  logic              rfnb_q, bav_q;

  logic              req_edge, bav_edge;
  logic              byte_edge, take;
  logic              last_lane, last_sec;
  logic              tmo_hit, timed;
  logic [7:0]        sel_byte;
  logic [DATA_W-1:0] ins_word;

  byte_lane_mux #(
    .DATA_W   (DATA_W),
    .MSB_FIRST(MSB_FIRST),
    .LANE_W   (LANE_W)
  ) u_lane (
    .word_i(mode_q ? asm_q : mem_rdata),
    .idx_i (lane_q),
    .byte_i(sd_dout),
    .byte_o(sel_byte),
    .word_o(ins_word)
  );

  assign req_edge  = sd_ready_for_next_byte & ~rfnb_q;
  assign bav_edge  = sd_byte_available & ~bav_q;
  assign byte_edge = (state_q == S_XFER) &
                     (mode_q ? bav_edge : req_edge);
  assign take      = byte_edge & (bidx_q < 10'd512);
  assign last_lane = (lane_q == LANE_W'(BPW - 1));
  assign last_sec  = (sec_q == SEC_W'(SECTORS - 1));
  assign tmo_hit   = (tmo_q == 32'(TIMEOUT - 1));
  assign timed     = (state_q == S_ISSUE) |
                     (state_q == S_WAIT_BUSY) |
                     (state_q == S_XFER);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sec_d   = sec_q;
    addr_d  = addr_q;
    maddr_d = maddr_q;
    bidx_d  = bidx_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    din_d   = din_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cks_d   = cks_q;

    // A load write advances the address one cycle after the strobe.
    if (we_q) maddr_d = maddr_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          addr_d  = 32'(slot) << SLOT_SHIFT;
          sec_d   = '0;
          maddr_d = '0;
          bidx_d  = '0;
          lane_d  = '0;
          err_d   = 1'b0;
          cks_d   = '0;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (sd_ready) begin
          wr_d    = (mode_q == MODE_SAVE);
          rd_d    = (mode_q == MODE_LOAD);
          state_d = S_WAIT_BUSY;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_WAIT_BUSY: begin
        if (!sd_ready) begin
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          state_d = S_XFER;
        end else if (tmo_hit) begin
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_XFER: begin
        if (take) begin
          bidx_d = bidx_q + 10'd1;
          lane_d = last_lane ? '0 : lane_q + 1'b1;
          if (mode_q == MODE_SAVE) begin
            din_d = sel_byte;
            if (last_lane) maddr_d = maddr_q + 1'b1;
          end else begin
            asm_d = ins_word;
            if (last_lane) begin
              wdata_d = ins_word;
              we_d    = 1'b1;
            end
          end
        end
        if (sd_ready) begin
          state_d = S_NEXT;
        end else if (tmo_hit && !byte_edge) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_NEXT: begin
        if (last_sec) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          sec_d   = sec_q + 1'b1;
          addr_d  = addr_q + 32'd512;
          bidx_d  = '0;
          lane_d  = '0;
          maddr_d = ADDR_W'((32'(sec_q) + 32'd1) * WPS);
          state_d = S_ISSUE;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef HIST_XFER_CKSUM_EN
    if (take) begin
      cks_d = cks_q + {8'h00, (mode_q ? sd_dout : sel_byte)};
    end
    if (state_q == S_NEXT && last_sec &&
        mode_q == MODE_LOAD && cks_q != cksum_exp) begin
      err_d = 1'b1;
    end
`else
    cks_d = '0;
`endif

    // Counter restarts on any state change or counted byte edge.
    if (!timed || state_d != state_q || byte_edge) tmo_d = '0;
    else tmo_d = tmo_q + 32'd1;
  end

`ifndef HIST_XFER_CKSUM_EN
  logic unused_cksum_exp;
  assign unused_cksum_exp = ^cksum_exp;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      sec_q   <= '0;
      addr_q  <= '0;
      maddr_q <= '0;
      bidx_q  <= '0;
      lane_q  <= '0;
      asm_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      din_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      cks_q   <= '0;
      rfnb_q  <= 1'b0;
      bav_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sec_q   <= sec_d;
      addr_q  <= addr_d;
      maddr_q <= maddr_d;
      bidx_q  <= bidx_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      cks_q   <= cks_d;
      rfnb_q  <= sd_ready_for_next_byte;
      bav_q   <= sd_byte_available;
    end
  end

  assign mem_addr   = maddr_q;
  assign mem_wdata  = wdata_q;
  assign mem_we     = we_q;
  assign sd_address = addr_q;
  assign sd_wr      = wr_q;
  assign sd_rd      = rd_q;
  assign sd_din     = din_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign cksum      = cks_q;

endmodule

// File: tb/tb_histogram_xfer.sv
// Bench for histogram_xfer: SD controller + BRAM models, scoreboard monitor.
// Default parameters with TIMEOUT shortened to 64 cycles.
module tb_histogram_xfer;

  localparam int DW   = 16;
  localparam int BPW  = DW / 8;
  localparam int NS   = 4;
  localparam int NW   = NS * 4096 / DW;
  localparam int AW   = 10;
  localparam int TMO  = 64;
  localparam bit MSBF = 1'b1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [6:0]    slot = '0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          sd_ready = 1'b1;
  logic [31:0]   sd_address;
  logic          sd_wr, sd_rd;
  logic [7:0]    sd_din;
  logic          rfnb = 1'b0;
  logic [7:0]    sd_dout = '0;
  logic          bav = 1'b0;
  logic          busy, done, err;
  logic [15:0]   cksum;
  logic [15:0]   cksum_exp = '0;

  histogram_xfer #(
    .DATA_W(DW), .SECTORS(NS), .SLOT_W(7), .SLOT_SHIFT(11),
    .MSB_FIRST(MSBF), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .slot(slot),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .sd_ready(sd_ready), .sd_address(sd_address),
    .sd_wr(sd_wr), .sd_rd(sd_rd), .sd_din(sd_din),
    .sd_ready_for_next_byte(rfnb), .sd_dout(sd_dout),
    .sd_byte_available(bav), .busy(busy), .done(done), .err(err),
    .cksum(cksum), .cksum_exp(cksum_exp)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] bram [0:NW-1];
  always @(posedge clk) begin
    mem_rdata <= bram[mem_addr];
    if (mem_we) bram[mem_addr] <= mem_wdata;
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic [7:0]  exp_bytes [$];
  logic [31:0] exp_addr [$];
  logic        exp_rd [$];
  wr_t         exp_wr [$];
  logic [7:0]  ld_q [$];
  logic [15:0] exp_ck;

  int checks = 0;
  int passes = 0;
  int done_cnt = 0;
  int sent = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h required %h", nm, act, req);
  endtask

  task automatic fail(input string nm);
    checks++;
    $display("FAIL %s: got no/unexpected event, required expected one", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic strb_n;
    logic rf_n;
    bit   pend;
    wr_t  w;
    strb_n = 1'b0;
    rf_n   = 1'b0;
    pend   = 1'b0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if ((sd_wr | sd_rd) && !strb_n) begin
        if (exp_addr.size() == 0) fail("unexpected_strobe");
        else begin
          chk("sd_address", sd_address, exp_addr.pop_front());
          chk("strobe_kind", {31'b0, sd_rd}, {31'b0, exp_rd.pop_front()});
        end
      end
      strb_n = sd_wr | sd_rd;
      if (pend) begin
        pend = 1'b0;
        if (exp_bytes.size() == 0) fail("unexpected_byte");
        else begin
          chk("sd_din", {24'b0, sd_din}, {24'b0, exp_bytes.pop_front()});
          sent++;
        end
      end
      if (mon_en && rfnb && !rf_n) pend = 1'b1;
      rf_n = rfnb;
      if (mem_we) begin
        if (exp_wr.size() == 0) fail("unexpected_mem_we");
        else begin
          w = exp_wr.pop_front();
          chk("we_addr", 32'(mem_addr), 32'(w.a));
          chk("we_data", 32'(mem_wdata), 32'(w.d));
        end
      end
    end
  endtask

  function automatic int lane_shift(input int b);
    return MSBF ? (BPW - 1 - b) * 8 : b * 8;
  endfunction

  // Reference: slot base address, then whole-slot byte stream / word image.
  task automatic expect_xfer(input bit m, input logic [6:0] s);
    logic [DW-1:0] wd;
    logic [7:0]    b;
    exp_ck = '0;
    for (int k = 0; k < NS; k++) begin
      exp_addr.push_back({25'b0, s} * 32'd2048 + 32'(k) * 32'd512);
      exp_rd.push_back(m);
    end
    for (int w = 0; w < NW; w++) begin
      wd = '0;
      for (int i = 0; i < BPW; i++) begin
        if (!m) begin
          b = 8'((bram[w] >> lane_shift(i)) & 'hff);
          exp_bytes.push_back(b);
        end else begin
          b = ld_q[w * BPW + i];
          wd = wd | (DW'(b) << lane_shift(i));
        end
        exp_ck = exp_ck + 16'(b);
      end
      if (m) exp_wr.push_back('{a: AW'(w), d: wd});
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_sd_address", sd_address, 0);
    chk("rst_strobes", {30'b0, sd_wr, sd_rd}, 0);
    chk("rst_sd_din", {24'b0, sd_din}, 0);
    chk("rst_flags", {29'b0, busy, done, err}, 0);
    chk("rst_cksum", {16'b0, cksum}, 0);
  endtask

  task automatic do_start(input bit m, input logic [6:0] s);
    start = 1'b1;
    mode  = m;
    slot  = s;
    tick();
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 1);
    chk("err_cleared", {31'b0, err}, 0);
  endtask

  task automatic serve_sector(input bit m, input int extra, input int rst_at,
                              input int poke_at, output bit aborted);
    int            n;
    logic [AW-1:0] ma;
    logic [7:0]    dn;
    aborted = 1'b0;
    n = 0;
    while (!(sd_wr || sd_rd) && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) begin
      fail("strobe_wait");
      aborted = 1'b1;
      return;
    end
    repeat ($urandom_range(1, 3)) tick();
    sd_ready = 1'b0;
    mon_en = !m;
    for (int i = 0; i < 512; i++) begin
      repeat ($urandom_range(2, 3)) tick();
      if (i == rst_at) begin
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        tick();
        reset = 1'b1;
        sd_ready = 1'b1;
        mon_en = 1'b0;
        exp_bytes.delete();
        exp_addr.delete();
        exp_rd.delete();
        exp_wr.delete();
        ld_q.delete();
        aborted = 1'b1;
        return;
      end
      if (i == poke_at) begin
        start = 1'b1;
        mode  = ~m;
        slot  = 7'h55;
      end
      if (!m) rfnb = 1'b1;
      else begin
        sd_dout = ld_q.pop_front();
        bav = 1'b1;
      end
      tick();
      rfnb  = 1'b0;
      bav   = 1'b0;
      start = 1'b0;
    end
    if (extra > 0) begin
      repeat (4) tick();
      mon_en = 1'b0;
      ma = mem_addr;
      dn = sd_din;
      for (int i = 0; i < extra; i++) begin
        sd_dout = 8'($urandom);
        if (!m) rfnb = 1'b1;
        else bav = 1'b1;
        tick();
        rfnb = 1'b0;
        bav  = 1'b0;
        repeat (3) tick();
      end
      chk("extra_mem_addr", 32'(mem_addr), 32'(ma));
      if (!m) chk("extra_sd_din", {24'b0, sd_din}, {24'b0, dn});
    end
    repeat ($urandom_range(2, 4)) tick();
    sd_ready = 1'b1;
    tick();
  endtask

  task automatic run_xfer(input bit m, input logic [6:0] s,
                          input int extra_sec, input int rst_sec,
                          input int poke_sec, input bit exp_err);
    bit ab;
    int n, dc, s0;
    if (m) begin
      ld_q.delete();
      for (int i = 0; i < NS * 512; i++) ld_q.push_back(8'($urandom));
    end
    expect_xfer(m, s);
    dc = done_cnt;
    s0 = sent;
    do_start(m, s);
    for (int k = 0; k < NS; k++) begin
      serve_sector(m, (k == extra_sec) ? 3 : 0,
                   (k == rst_sec) ? 200 : -1,
                   (k == poke_sec) ? 100 : -1, ab);
      if (ab) begin
        repeat (5) tick();
        chk("no_done_on_reset", done_cnt, dc);
        return;
      end
    end
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!done) fail("done_wait");
    else begin
      chk("err_at_done", {31'b0, err}, {31'b0, exp_err});
      chk("busy_at_done", {31'b0, busy}, 0);
`ifdef HIST_XFER_CKSUM_EN
      chk("cksum", {16'b0, cksum}, {16'b0, exp_ck});
`else
      chk("cksum_tied", {16'b0, cksum}, 0);
`endif
    end
    chk("bytes_left", exp_bytes.size(), 0);
    chk("writes_left", exp_wr.size(), 0);
    chk("addrs_left", exp_addr.size(), 0);
    if (!m) chk("bytes_sent", sent - s0, NS * 512);
    tick();
    chk("one_done", done_cnt - dc, 1);
  endtask

  task automatic run_timeout(input logic [6:0] s);
    int n;
    exp_addr.push_back({25'b0, s} * 32'd2048);
    exp_rd.push_back(1'b0);
    do_start(1'b0, s);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) fail("timeout_done");
    else begin
      chk("timeout_err", {31'b0, err}, 1);
      chk("timeout_sd_wr", {31'b0, sd_wr}, 0);
      chk("timeout_latency_ok", {31'b0, (n >= TMO && n <= TMO + 4)}, 1);
    end
    tick();
    chk("err_sticky", {31'b0, err}, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs();
    tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < NW; i++) bram[i] = DW'(i);
    run_xfer(1'b0, 7'd3, -1, -1, -1, 1'b0);

    for (int i = 0; i < NW; i++) bram[i] = DW'($urandom);
    run_xfer(1'b0, 7'($urandom), 1, -1, 2, 1'b0);

    cksum_exp = 16'($urandom);
    run_xfer(1'b1, 7'($urandom), 3, -1, 0, 1'b0);

    run_timeout(7'd9);

    for (int i = 0; i < NW; i++) bram[i] = DW'($urandom);
    run_xfer(1'b0, 7'd42, -1, 2, -1, 1'b0);
    run_xfer(1'b0, 7'd127, -1, -1, -1, 1'b0);

`ifdef HIST_XFER_CKSUM_EN
    for (int j = 0; j < 2; j++) begin
      ld_q.delete();
      cksum_exp = (j == 0) ? 16'h0800 : 16'h0801;
      for (int i = 0; i < NS * 512; i++) ld_q.push_back(8'h01);
      expect_xfer(1'b1, 7'd5);
      chk("ones_model", {16'b0, exp_ck}, 32'h0800);
      do_start(1'b1, 7'd5);
      for (int k = 0; k < NS; k++) begin
        bit ab;
        serve_sector(1'b1, 0, -1, -1, ab);
      end
      repeat (3) @(negedge clk);
      chk("ones_cksum", {16'b0, cksum}, 32'h0800);
      chk("ones_err", {31'b0, err}, {31'b0, (j == 1)});
      tick();
    end
`endif

    repeat (5) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/histogram_xfer.md
# histogram_xfer

Parametrised bidirectional transfer engine between a word-wide histogram BRAM and the byte-serial SD-card controller. Saves (BRAM to SD) or loads (SD to BRAM) a slot of SECTORS consecutive 512-byte sectors. Supports configurable word width, byte order, a ready-timeout and an optional running checksum. Sits between the histogram BRAM port and sd_controller, driven by the slot-management FSM.

## Interface
- DATA_W, 16: BRAM word width; multiple of 8, range 8..32.
- SECTORS, 4: sectors per slot; power of two, 1..16.
- SLOT_W, 7: slot index width.
- SLOT_SHIFT, 11: byte-address shift per slot; must be at least log2(SECTORS*512).
- MSB_FIRST, 1: 1 = most significant byte of each word goes first on SD.
- TIMEOUT, 2^20: cycles allowed waiting on any sd_ready edge.
- ADDR_W: derived, log2(SECTORS*4096/DATA_W).
- clk, in, 1: single clock.
- reset, in, 1: asynchronous, active-low.
- start, in, 1: one-cycle request; sampled only in IDLE.
- mode, in, 1: 0 = save, 1 = load; sampled with start.
- slot, in, SLOT_W: slot index; sampled with start.
- mem_addr, out, ADDR_W: BRAM address; BRAM read latency is 1 cycle.
- mem_rdata, in, DATA_W: BRAM read data.
- mem_wdata, out, DATA_W: BRAM write data.
- mem_we, out, 1: one-cycle BRAM write strobe (load only).
- sd_ready, in, 1: controller idle.
- sd_address, out, 32: sector byte address.
- sd_wr / sd_rd, out, 1 each: command strobes, held until sd_ready falls.
- sd_din, out, 8: write byte.
- sd_ready_for_next_byte, in, 1: write byte request, rising-edge sensitive.
- sd_dout, in, 8: read byte.
- sd_byte_available, in, 1: read byte valid, rising-edge sensitive.
- busy, out, 1: high from the cycle after an accepted start until done.
- done, out, 1: one-cycle pulse at completion or abort.
- err, out, 1: sticky until next accepted start; set by timeout or checksum mismatch.
- cksum, out, 16: running byte checksum.
- cksum_exp, in, 16: expected checksum for load.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, XFER, NEXT, FINISH.
- IDLE + start:
  - latch mode and slot.
  - sd_address = slot << SLOT_SHIFT (zero-extended to 32 bits).
  - sector = 0, mem_addr = 0, byte index = 0, err = 0, cksum = 0.
  - go to ISSUE.
- ISSUE:
  - wait for sd_ready.
  - Then assert sd_wr (save) or sd_rd (load), and go to WAIT_BUSY.
- WAIT_BUSY:
  - on sd_ready = 0, drop the strobe and go to XFER.
- XFER, save:
  - On each rising edge of sd_ready_for_next_byte, drive sd_din with the selected byte of mem_rdata.
  - Byte selection follows MSB_FIRST.
  - After the last byte of a word, increment mem_addr.
- XFER, load:
  - On each rising edge of sd_byte_available, shift sd_dout into the assembly register in MSB_FIRST order.
  - After DATA_W/8 bytes, present mem_wdata at the current mem_addr and pulse mem_we for one cycle.
  - mem_addr increments the following cycle.
- XFER byte count:
  - Exactly 512 bytes per sector.
  - Byte edges beyond 512 are ignored.
  - XFER exits to NEXT when sd_ready returns high.
- NEXT:
  - If sector == SECTORS-1, go to FINISH.
  - Otherwise: sector+1, sd_address += 512, byte index = 0, mem_addr = (sector+1)*(4096/DATA_W), go to ISSUE.
- FINISH:
  - pulse done, drop busy, return to IDLE.
- Timeout: the counter resets on every state change and every byte edge. If it reaches TIMEOUT in ISSUE, WAIT_BUSY or XFER:
  - set err.
  - deassert sd_wr/sd_rd.
  - go to FINISH.
- start while busy is ignored, with no queuing.
- Width rules: sd_address arithmetic is 32-bit and wraps modulo 2^32. mem_addr wraps at 2^ADDR_W only after the final word.

## Timing
- Reset values: all outputs 0, state IDLE, err 0, cksum 0.
- Reset mid-operation: immediate return to IDLE, strobes low, no done pulse.
- Accepted start to first strobe: 2 cycles if sd_ready is already high.
- Byte edges must be at least 3 cycles apart. This covers BRAM latency plus the registered sd_din/mem_we.
- sd_din is valid from the cycle after the request edge until the next request edge.
- done is asserted exactly 1 cycle after the final NEXT evaluation.

## Configuration
- HIST_XFER_CKSUM_EN defined:
  - cksum = 16-bit wrap-around sum of every transferred byte.
  - In load mode, cksum != cksum_exp at FINISH sets err in the same cycle as done.
- Not defined:
  - cksum is tied to 0 and cksum_exp is ignored.
  - err is set only by timeout.

## Structure
- Package hist_xfer_pkg holds:
  - the state enum.
  - SECTOR_BYTES = 512.
  - the mode encodings.
  - the log2 helper used for ADDR_W.
- One sub-module, byte_lane_mux: selects/assembles byte lanes by index and MSB_FIRST, shared by the save and load paths.

## Test plan
- Save, default params, slot 3, BRAM word i = i:
  - sd_address sequence 0x1800, 0x1A00, 0x1C00, 0x1E00.
  - Sector 0 bytes are 00 00 00 01 00 02 ...
  - done after 2048 byte requests.
- Load, MSB_FIRST = 0, DATA_W = 32, SECTORS = 1, bytes 0x00..0xFF repeated:
  - 128 mem_we pulses.
  - word 0 = 0x03020100.
  - word 127 = 0xFFFEFDFC.
- Timeout: sd_ready held high after sd_wr in save, TIMEOUT = 64:
  - err = 1 and done at cycle 64 of WAIT_BUSY.
  - sd_wr = 0.
- reset pulled low mid-sector 2: all outputs 0 next cycle. A subsequent start restarts at sector 0 with a correct address.
- start asserted during busy, plus extra byte edges after byte 512: both are ignored, mem_addr is unchanged and exactly 4 sectors are transferred.
- With HIST_XFER_CKSUM_EN, load of an all-0x01 slot:
  - cksum = 0x0800.
  - err = 0 when cksum_exp = 0x0800.
  - err = 1 when cksum_exp = 0x0801.
